// File: rtl/flac_pkg.sv
// Shared FLAC decode definitions: widths, Rice decoder state encoding and
// the zigzag unfold used by every residual path (Rice, escape, verbatim).
package flac_pkg;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned ACC_W   = 32;
    localparam int unsigned COUNT_W = 16;
    localparam int unsigned PARAM_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        UNARY = 2'd1,
        REM   = 2'd2,
        FIN   = 2'd3
    } state_e;

    // Map the unsigned folded value back to two's complement:
    // even u -> u/2, odd u -> -(u+1)/2.
    function automatic logic [ACC_W-1:0] zigzag_unfold(input logic [ACC_W-1:0] u);
        return (u >> 1) ^ {ACC_W{u[0]}};
    endfunction

endpackage

// File: rtl/rice_residual_decoder.sv
// Rice residual decoder: consumes a serial MSB-first bitstream of Rice
// codewords (unary quotient, k-bit remainder) and emits one signed residual
// per codeword for the downstream fixed-predictor stage.
//
// Ports
//   iClock      clock, all logic on posedge
//   iReset      synchronous active-high reset
//   iStart      pulse: latch iRiceParam/iCount and begin a partition (IDLE only)
//   iRiceParam  Rice parameter k
//   iCount      number of residuals in the partition
//   iEnable     iBit is valid this cycle
//   iBit        next stream bit
//   oResidual   decoded residual, held until the next oValid
//   oValid      one-cycle strobe: oResidual updated
//   oDone       one-cycle strobe: partition complete
//   oBusy       partition in progress
//   oOverflow   sticky: a decoded value did not fit DATA_W signed
module rice_residual_decoder
    import flac_pkg::*;
(
    input  logic               iClock,
    input  logic               iReset,
    input  logic               iStart,
    input  logic [PARAM_W-1:0] iRiceParam,
    input  logic [COUNT_W-1:0] iCount,
    input  logic               iEnable,
    input  logic               iBit,
    output logic [DATA_W-1:0]  oResidual,
    output logic               oValid,
    output logic               oDone,
    output logic               oBusy,
    output logic               oOverflow
);

    state_e             state_q, state_d;
    logic [PARAM_W-1:0] k_q, k_d;
    logic [PARAM_W-1:0] bitcnt_q, bitcnt_d;
    logic [COUNT_W-1:0] remaining_q, remaining_d;
    logic [ACC_W-1:0]   quot_q, quot_d;
    logic [ACC_W-1:0]   rem_q, rem_d;
    logic [DATA_W-1:0]  residual_q, residual_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               ovf_q, ovf_d;

    logic               emit_c;
    logic [ACC_W-1:0]   rem_shift_c;
    logic [ACC_W-1:0]   rem_emit_c;
    logic [ACC_W-1:0]   folded_c;
    logic [ACC_W-1:0]   unfolded_c;
    logic               fits_c;

    // Remainder with the current bit appended; k never exceeds ACC_W-2 so the
    // dropped MSB is always zero.
    assign rem_shift_c = ACC_W'({rem_q, iBit});

    // The emitting bit is the last remainder bit in REM, or the terminating
    // unary '1' when k==0 (remainder empty).
    assign rem_emit_c  = (state_q == REM) ? rem_shift_c : '0;
    assign folded_c    = (quot_q << k_q) | rem_emit_c;
    assign unfolded_c  = zigzag_unfold(folded_c);

    // Fits DATA_W signed when all bits from the DATA_W-1 sign position up agree.
    assign fits_c = (&unfolded_c[ACC_W-1:DATA_W-1]) | ~(|unfolded_c[ACC_W-1:DATA_W-1]);

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        bitcnt_d    = bitcnt_q;
        remaining_d = remaining_q;
        quot_d      = quot_q;
        rem_d       = rem_q;
        residual_d  = residual_q;
        valid_d     = 1'b0;
        done_d      = 1'b0;
        busy_d      = busy_q;
        ovf_d       = ovf_q;
        emit_c      = 1'b0;

        case (state_q)
            IDLE: begin
                if (iStart) begin
                    k_d         = iRiceParam;
                    remaining_d = iCount;
                    quot_d      = '0;
                    rem_d       = '0;
                    ovf_d       = 1'b0;
                    if (iCount == '0) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = UNARY;
                        busy_d  = 1'b1;
                    end
                end
            end
            UNARY: begin
                if (iEnable) begin
                    if (!iBit) begin
                        quot_d = quot_q + ACC_W'(1);
                        if (&quot_q) begin
                            ovf_d = 1'b1;
                        end
                    end else if (k_q == '0) begin
                        emit_c = 1'b1;
                    end else begin
                        state_d  = REM;
                        bitcnt_d = k_q;
                    end
                end
            end
            REM: begin
                if (iEnable) begin
                    rem_d    = rem_shift_c;
                    bitcnt_d = bitcnt_q - PARAM_W'(1);
                    if (bitcnt_q == PARAM_W'(1)) begin
                        emit_c = 1'b1;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Codeword complete: publish the residual and advance the partition.
        if (emit_c) begin
            residual_d  = unfolded_c[DATA_W-1:0];
            valid_d     = 1'b1;
            quot_d      = '0;
            rem_d       = '0;
            remaining_d = remaining_q - COUNT_W'(1);
            if (!fits_c) begin
                ovf_d = 1'b1;
            end
            if (remaining_q == COUNT_W'(1)) begin
                state_d = FIN;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end else begin
                state_d = UNARY;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_q     <= IDLE;
            k_q         <= '0;
            bitcnt_q    <= '0;
            remaining_q <= '0;
            quot_q      <= '0;
            rem_q       <= '0;
            residual_q  <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            bitcnt_q    <= bitcnt_d;
            remaining_q <= remaining_d;
            quot_q      <= quot_d;
            rem_q       <= rem_d;
            residual_q  <= residual_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            ovf_q       <= ovf_d;
        end
    end

    assign oResidual = residual_q;
    assign oValid    = valid_q;
    assign oDone     = done_q;
    assign oBusy     = busy_q;
    assign oOverflow = ovf_q;

endmodule

// File: tb/tb_rice_residual_decoder.sv
module tb_rice_residual_decoder;

    logic        iClock = 1'b0;
    logic        iReset;
    logic        iStart;
    logic [4:0]  iRiceParam;
    logic [15:0] iCount;
    logic        iEnable;
    logic        iBit;
    logic [15:0] oResidual;
    logic        oValid;
    logic        oDone;
    logic        oBusy;
    logic        oOverflow;

    rice_residual_decoder dut (
        .iClock     (iClock),
        .iReset     (iReset),
        .iStart     (iStart),
        .iRiceParam (iRiceParam),
        .iCount     (iCount),
        .iEnable    (iEnable),
        .iBit       (iBit),
        .oResidual  (oResidual),
        .oValid     (oValid),
        .oDone      (oDone),
        .oBusy      (oBusy),
        .oOverflow  (oOverflow)
    );

    always #5 iClock = ~iClock;

    typedef struct {
        logic [15:0] res;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   done_only = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference: u = q*2^k + r, even -> u/2, odd -> -(u+1)/2.
    function automatic longint model_value(int unsigned q, int unsigned k, longint unsigned r);
        longint unsigned u;
        u = (longint'(q) << k) + r;
        if (u % 2 == 1) return -longint'((u + 1) / 2);
        return longint'(u / 2);
    endfunction

    function automatic logic model_ovf(int unsigned q, int unsigned k, longint unsigned r);
        longint v;
        v = model_value(q, k, r);
        return (v < -32768) || (v > 32767);
    endfunction

    task automatic tick();
        @(posedge iClock);
        #1;
    endtask

    task automatic check(input string tag, input longint obs, input longint expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Start pulse; iEnable/iBit deliberately active to show they are ignored.
    task automatic start(input int unsigned k, input int unsigned count);
        iStart     = 1'b1;
        iRiceParam = 5'(k);
        iCount     = 16'(count);
        iEnable    = 1'b1;
        iBit       = 1'b1;
        tick();
        iStart  = 1'b0;
        iEnable = 1'b0;
    endtask

    task automatic send_bit(input logic b, input bit gap);
        iEnable = 1'b1;
        iBit    = b;
        tick();
        iEnable = 1'b0;
        if (gap) begin
            iBit = ~b;
            tick();
        end
    endtask

    task automatic send_code(input int unsigned q, input int unsigned k, input longint unsigned r,
                             input logic last, input bit gap);
        exp_t e;
        longint v;
        v     = model_value(q, k, r);
        e.res  = v[15:0];
        e.last = last;
        exp_q.push_back(e);
        for (int i = 0; i < int'(q); i++) send_bit(1'b0, gap);
        send_bit(1'b1, gap);
        for (int i = int'(k) - 1; i >= 0; i--) send_bit(r[i], gap);
    endtask

    // Scoreboard: compare each oValid against the oldest expectation.
    always @(negedge iClock) begin
        if (!iReset) begin
            if (oValid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $error("FAIL unexpected_valid: observed residual %0d expected no output", $signed(oResidual));
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    n_cmp++;
                    assert (oResidual === e.res) else begin
                        n_bad++;
                        $error("FAIL residual: observed %0d expected %0d", $signed(oResidual), $signed(e.res));
                    end
                    n_cmp++;
                    assert (oDone === e.last) else begin
                        n_bad++;
                        $error("FAIL done_with_valid: observed %0b expected %0b", oDone, e.last);
                    end
                end
            end else if (oDone) begin
                n_cmp++;
                assert (done_only > 0) else begin
                    n_bad++;
                    $error("FAIL done_alone: observed pending %0d expected >0", done_only);
                end
                if (done_only > 0) done_only--;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        iReset = 1'b1; iStart = 1'b0; iRiceParam = '0; iCount = '0; iEnable = 1'b0; iBit = 1'b0;
        tick(); tick(); tick();
        check("rst_residual", longint'(oResidual), 0);
        check("rst_valid",    longint'(oValid), 0);
        check("rst_done",     longint'(oDone), 0);
        check("rst_busy",     longint'(oBusy), 0);
        check("rst_ovf",      longint'(oOverflow), 0);
        iReset = 1'b0;
        tick();

        // 1: k=2, count=1, bits 0,0,1,1,0 -> +5
        start(2, 1);
        check("t1_busy", longint'(oBusy), 1);
        send_code(2, 2, 2, 1'b1, 1'b0);
        check("t1_busy_end", longint'(oBusy), 0);
        tick();

        // 2: k=0, count=3 -> 0, -1, +1
        start(0, 3);
        send_code(0, 0, 0, 1'b0, 1'b0);
        send_code(1, 0, 0, 1'b0, 1'b0);
        send_code(2, 0, 0, 1'b1, 1'b0);
        tick();

        // 3: k=3, count=2, iEnable toggling, bits 1,1,1,1 | 1,0,0,0
        start(3, 2);
        send_code(0, 3, 7, 1'b0, 1'b1);
        send_code(0, 3, 0, 1'b1, 1'b1);
        tick();

        // 4: count=0 -> lone oDone; iStart while busy is ignored
        done_only++;
        start(4, 0);
        check("t4_done", longint'(oDone), 1);
        check("t4_busy", longint'(oBusy), 0);
        tick();
        start(1, 2);
        iStart = 1'b1; iRiceParam = 5'd0; iCount = 16'd0;
        tick();
        iStart = 1'b0;
        check("t4_busy_hold", longint'(oBusy), 1);
        send_code(1, 1, 1, 1'b0, 1'b0);
        send_code(0, 1, 0, 1'b1, 1'b0);
        tick();

        // 5: k=15, u=32767 then u=65536 (overflow)
        start(15, 2);
        send_code(0, 15, 32767, 1'b0, 1'b0);
        check("t5_ovf_lo", longint'(oOverflow), longint'(model_ovf(0, 15, 32767)));
        send_code(2, 15, 0, 1'b1, 1'b0);
        check("t5_ovf_hi", longint'(oOverflow), longint'(model_ovf(2, 15, 0)));
        tick();
        check("t5_ovf_sticky", longint'(oOverflow), 1);
        start(0, 1);
        check("t5_ovf_clear", longint'(oOverflow), 0);
        send_code(0, 0, 0, 1'b1, 1'b0);
        tick();

        // 6: reset mid-UNARY after 3 zeros, then k=1 bits 1,1
        start(1, 2);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        iReset = 1'b1;
        tick();
        check("t6_residual", longint'(oResidual), 0);
        check("t6_busy",     longint'(oBusy), 0);
        check("t6_valid",    longint'(oValid), 0);
        check("t6_ovf",      longint'(oOverflow), 0);
        iReset = 1'b0;
        tick();
        start(1, 1);
        send_code(0, 1, 1, 1'b1, 1'b0);
        tick(); tick();

        check("sb_drained",   longint'(exp_q.size()), 0);
        check("done_drained", longint'(done_only), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
